// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with exception state and PC redirect
module pipe_ctrl #(
  parameter logic [29:0] EXP_VECTOR = 30'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // stall/flush towards the pipeline registers
  output logic        if_stall_o,
  output logic        if_flush_o,
  output logic        id_stall_o,
  output logic        id_flush_o,
  output logic        ex_stall_o,
  output logic        ex_flush_o,
  output logic        mem_stall_o,
  output logic        mem_flush_o,
  // bus status
  input  logic        if_busy_i,
  input  logic        mem_busy_i,
  // decode-stage hazard and branch information
  input  logic [4:0]  dec_ra_addr_i,
  input  logic [4:0]  dec_rb_addr_i,
  input  logic        dec_ra_use_i,
  input  logic        dec_rb_use_i,
  input  logic        dec_br_taken_i,
  input  logic [29:0] dec_br_addr_i,
  // instruction currently in EX (ID register outputs)
  input  logic        id_en_i,
  input  logic [1:0]  id_mem_op_i,
  input  logic [4:0]  id_dst_addr_i,
  input  logic        id_gpr_we_n_i,
  // MEM-stage events
  input  logic        mem_en_i,
  input  logic [29:0] mem_pc_i,
  input  logic [2:0]  mem_exp_code_i,
  input  logic [1:0]  mem_ctrl_op_i,
  // redirect and exception state
  output logic [29:0] new_pc_o,
  output logic        new_pc_valid_o,
  output logic [29:0] epc_o,
  output logic [2:0]  exp_cause_o,
  output logic        exe_mode_o,
  output logic        halted_o
);

  localparam logic [1:0] MEM_OP_LDW     = 2'd1;
  localparam logic [1:0] CTRL_OP_ERET   = 2'd2;
  localparam logic [2:0] ISA_EXP_NO_EXP = 3'd0;
  localparam logic       ENABLE_N       = 1'b0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q;
  logic [29:0] epc_q;
  logic [2:0]  cause_q;
  logic        exe_mode_q;
  logic        halted_q;

  // per-stage controls, bit 3 = IF ... bit 0 = MEM
  logic [3:0]  stall;
  logic [3:0]  flush;
  logic        busy;
  logic        exc_take;
  logic        eret_take;
  logic        load_use;

  assign busy      = if_busy_i | mem_busy_i;
  assign exc_take  = mem_en_i && (mem_exp_code_i != ISA_EXP_NO_EXP);
  assign eret_take = mem_en_i && (mem_ctrl_op_i == CTRL_OP_ERET);
  assign load_use  = id_en_i && (id_mem_op_i == MEM_OP_LDW) && (id_gpr_we_n_i == ENABLE_N) &&
                     ((dec_ra_use_i && (dec_ra_addr_i == id_dst_addr_i)) ||
                      (dec_rb_use_i && (dec_rb_addr_i == id_dst_addr_i)));

  // prioritised event decode: first matching event owns stall/flush/redirect this cycle
  always_comb begin
    stall          = 4'b0000;
    flush          = 4'b0000;
    new_pc_o       = 30'h0;
    new_pc_valid_o = 1'b0;
    if (rst_i) begin
      flush = 4'b1111;
    end else if (state_q == ST_HALT) begin
      stall = 4'b1111;
    end else if (busy) begin
      stall = 4'b1111;
    end else if (exc_take) begin
      flush          = 4'b1111;
      new_pc_o       = EXP_VECTOR;
      new_pc_valid_o = 1'b1;
    end else if (eret_take) begin
      flush          = 4'b1111;
      new_pc_o       = epc_q;
      new_pc_valid_o = 1'b1;
    end else if (load_use) begin
      // hold fetch and inject a bubble into EX; the branch waits for the retry
      stall[3] = 1'b1;
      flush[2] = 1'b1;
    end else if (dec_br_taken_i) begin
      flush[3]       = 1'b1;
      new_pc_o       = dec_br_addr_i;
      new_pc_valid_o = 1'b1;
    end
  end

  assign if_stall_o  = stall[3];
  assign id_stall_o  = stall[2];
  assign ex_stall_o  = stall[1];
  assign mem_stall_o = stall[0];
  assign if_flush_o  = flush[3];
  assign id_flush_o  = flush[2];
  assign ex_flush_o  = flush[1];
  assign mem_flush_o = flush[0];

  // exception FSM and saved state; busy cycles defer MEM events rather than drop them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      epc_q      <= 30'h0;
      cause_q    <= ISA_EXP_NO_EXP;
      exe_mode_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN, ST_TRAP: begin
          state_q <= ST_RUN;
          if (!busy) begin
            if (exc_take) begin
              if (exe_mode_q) begin
                // fault inside the handler: freeze, keep the original EPC/cause
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
              end else begin
                state_q    <= ST_TRAP;
                epc_q      <= mem_pc_i;
                cause_q    <= mem_exp_code_i;
                exe_mode_q <= 1'b1;
              end
            end else if (eret_take) begin
              exe_mode_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign epc_o       = epc_q;
  assign exp_cause_o = cause_q;
  assign exe_mode_o  = exe_mode_q;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl with directed and random stimulus
module tb_pipe_ctrl;

  localparam logic [29:0] VEC      = 30'h0000_0200;
  localparam logic [1:0]  LDW      = 2'd1;
  localparam logic [1:0]  ERET     = 2'd2;
  localparam logic [2:0]  OVERFLOW = 3'd3;

  typedef struct {
    logic        rst, if_busy, mem_busy;
    logic [4:0]  ra, rb;
    logic        ra_use, rb_use, br;
    logic [29:0] br_addr;
    logic        id_en;
    logic [1:0]  id_mem_op;
    logic [4:0]  dst;
    logic        we_n, mem_en;
    logic [29:0] mem_pc;
    logic [2:0]  code;
    logic [1:0]  ctrl;
  } stim_t;

  typedef struct {
    logic [7:0]  sf;     // {stall if,id,ex,mem, flush if,id,ex,mem}
    logic        nvalid;
    logic [29:0] npc;
    logic [29:0] epc;
    logic [2:0]  cause;
    logic        mode;
    logic        halted;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_busy, mem_busy, ra_use, rb_use, br, id_en, we_n, mem_en;
  logic [4:0]  ra, rb, dst;
  logic [29:0] br_addr, mem_pc;
  logic [1:0]  id_mem_op, ctrl;
  logic [2:0]  code;
  logic        if_s, if_f, id_s, id_f, ex_s, ex_f, mem_s, mem_f;
  logic [29:0] new_pc, epc;
  logic        new_pc_valid, exe_mode, halted;
  logic [2:0]  exp_cause;

  pipe_ctrl #(.EXP_VECTOR(VEC)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_stall_o(if_s), .if_flush_o(if_f), .id_stall_o(id_s), .id_flush_o(id_f),
    .ex_stall_o(ex_s), .ex_flush_o(ex_f), .mem_stall_o(mem_s), .mem_flush_o(mem_f),
    .if_busy_i(if_busy), .mem_busy_i(mem_busy),
    .dec_ra_addr_i(ra), .dec_rb_addr_i(rb), .dec_ra_use_i(ra_use), .dec_rb_use_i(rb_use),
    .dec_br_taken_i(br), .dec_br_addr_i(br_addr),
    .id_en_i(id_en), .id_mem_op_i(id_mem_op), .id_dst_addr_i(dst), .id_gpr_we_n_i(we_n),
    .mem_en_i(mem_en), .mem_pc_i(mem_pc), .mem_exp_code_i(code), .mem_ctrl_op_i(ctrl),
    .new_pc_o(new_pc), .new_pc_valid_o(new_pc_valid), .epc_o(epc), .exp_cause_o(exp_cause),
    .exe_mode_o(exe_mode), .halted_o(halted)
  );

  // reference model state: what the architecture has committed so far
  logic [29:0] m_epc;
  logic [2:0]  m_cause;
  logic        m_mode, m_halted;

  exp_t  sb[$];
  stim_t s;
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic stim_t idle();
    stim_t t;
    t = '{rst:0, if_busy:0, mem_busy:0, ra:0, rb:0, ra_use:0, rb_use:0, br:0, br_addr:0,
          id_en:0, id_mem_op:0, dst:0, we_n:1, mem_en:0, mem_pc:0, code:0, ctrl:0};
    return t;
  endfunction

  // apply one cycle of stimulus, predict the observable response, then commit the model
  task automatic step(input stim_t t);
    exp_t e;
    bit   exc, eret, lu;
    @(negedge clk);
    rst = t.rst; if_busy = t.if_busy; mem_busy = t.mem_busy;
    ra = t.ra; rb = t.rb; ra_use = t.ra_use; rb_use = t.rb_use; br = t.br; br_addr = t.br_addr;
    id_en = t.id_en; id_mem_op = t.id_mem_op; dst = t.dst; we_n = t.we_n;
    mem_en = t.mem_en; mem_pc = t.mem_pc; code = t.code; ctrl = t.ctrl;
    #1;
    exc  = t.mem_en && (t.code != 3'd0);
    eret = t.mem_en && (t.ctrl == ERET);
    lu   = t.id_en && (t.id_mem_op == LDW) && !t.we_n &&
           ((t.ra_use && t.ra == t.dst) || (t.rb_use && t.rb == t.dst));
    e.epc = m_epc; e.cause = m_cause; e.mode = m_mode; e.halted = m_halted;
    e.nvalid = 1'b0; e.npc = 30'h0;
    if (t.rst)                         e.sf = 8'b0000_1111;
    else if (m_halted)                 e.sf = 8'b1111_0000;
    else if (t.if_busy || t.mem_busy)  e.sf = 8'b1111_0000;
    else if (exc)  begin e.sf = 8'b0000_1111; e.nvalid = 1'b1; e.npc = VEC;   end
    else if (eret) begin e.sf = 8'b0000_1111; e.nvalid = 1'b1; e.npc = m_epc; end
    else if (lu)                       e.sf = 8'b1000_0100;
    else if (t.br) begin e.sf = 8'b0000_1000; e.nvalid = 1'b1; e.npc = t.br_addr; end
    else                               e.sf = 8'b0000_0000;
    sb.push_back(e);
    if (t.rst) begin
      m_epc = 30'h0; m_cause = 3'd0; m_mode = 1'b0; m_halted = 1'b0;
    end else if (!m_halted && !(t.if_busy || t.mem_busy)) begin
      if (exc) begin
        if (m_mode) m_halted = 1'b1;
        else begin m_epc = t.mem_pc; m_cause = t.code; m_mode = 1'b1; end
      end else if (eret) m_mode = 1'b0;
    end
  endtask

  // monitor: every cycle the DUT presents a response, compare it to the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if ({if_s, id_s, ex_s, mem_s, if_f, id_f, ex_f, mem_f} !== e.sf) begin
          n_fail++;
          $display("FAIL stall_flush got %b want %b", {if_s, id_s, ex_s, mem_s, if_f, id_f, ex_f, mem_f}, e.sf);
        end
        n_tests++;
        if (new_pc_valid !== e.nvalid || new_pc !== e.npc) begin
          n_fail++;
          $display("FAIL redirect got %b/%h want %b/%h", new_pc_valid, new_pc, e.nvalid, e.npc);
        end
        n_tests++;
        if (epc !== e.epc || exp_cause !== e.cause || exe_mode !== e.mode || halted !== e.halted) begin
          n_fail++;
          $display("FAIL exc_state got epc=%h cause=%0d mode=%b halted=%b want epc=%h cause=%0d mode=%b halted=%b",
                   epc, exp_cause, exe_mode, halted, e.epc, e.cause, e.mode, e.halted);
        end
      end
    end
  end

  initial begin
    m_epc = 30'h0; m_cause = 3'd0; m_mode = 1'b0; m_halted = 1'b0;
    s = idle(); s.rst = 1'b1;
    step(s); step(s);
    s = idle(); step(s);

    // load-use hit, then cleared, then a non-matching source
    s = idle(); s.id_en = 1; s.id_mem_op = LDW; s.dst = 5; s.we_n = 0; s.ra_use = 1; s.ra = 5;
    step(s);
    s = idle(); step(s);
    s = idle(); s.id_en = 1; s.id_mem_op = LDW; s.dst = 5; s.we_n = 0; s.ra_use = 1; s.ra = 6;
    step(s);

    // taken branch, then branch suppressed by load-use on rb
    s = idle(); s.br = 1; s.br_addr = 30'h100; step(s);
    s.id_en = 1; s.id_mem_op = LDW; s.dst = 9; s.we_n = 0; s.rb_use = 1; s.rb = 9; step(s);
    s = idle(); step(s);

    // exception, then ERET back to the saved PC
    s = idle(); s.mem_en = 1; s.mem_pc = 30'h40; s.code = OVERFLOW; s.ctrl = ERET; step(s);
    s = idle(); step(s);
    s = idle(); s.mem_en = 1; s.ctrl = ERET; step(s);
    s = idle(); step(s);

    // exception deferred by three busy cycles, taken on the fourth
    s = idle(); s.mem_en = 1; s.mem_pc = 30'h84; s.code = 3'd2; s.mem_busy = 1; s.br = 1;
    step(s); step(s); step(s);
    s.mem_busy = 0; step(s);
    s = idle(); step(s);

    // double fault inside the handler, stays halted, then reset clears it
    s = idle(); s.mem_en = 1; s.mem_pc = 30'h99; s.code = 3'd5; step(s);
    s = idle(); s.br = 1; s.br_addr = 30'h7; step(s); step(s);
    s = idle(); s.rst = 1; step(s);
    s = idle(); step(s);

    // random traffic with occasional resets to escape HALT
    for (int i = 0; i < 3000; i++) begin
      s.rst       = ($urandom_range(0, 39) == 0);
      s.if_busy   = ($urandom_range(0, 7) == 0);
      s.mem_busy  = ($urandom_range(0, 7) == 0);
      s.ra        = 5'($urandom_range(0, 7));
      s.rb        = 5'($urandom_range(0, 7));
      s.ra_use    = 1'($urandom);
      s.rb_use    = 1'($urandom);
      s.br        = 1'($urandom);
      s.br_addr   = 30'($urandom);
      s.id_en     = 1'($urandom);
      s.id_mem_op = 2'($urandom);
      s.dst       = 5'($urandom_range(0, 7));
      s.we_n      = 1'($urandom);
      s.mem_en    = 1'($urandom);
      s.mem_pc    = 30'($urandom);
      s.code      = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(1, 7));
      s.ctrl      = 2'($urandom);
      step(s);
    end

    s = idle(); step(s);
    @(negedge clk); #5;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
